multicycle_cu: RTL
==================

MULTICYCLE_CU -- requirements
Module: multicycle_cu

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set register-file, operand, result and debug data width.
REQ-002 Parameter REG_ADDR_BITS, default 2, SHALL set register-index width; NUM_REGS = 2**REG_ADDR_BITS.
REQ-003 Parameter OFFSET_WIDTH, default 8, SHALL set offset field and output width.
REQ-004 Parameter ZERO_REG, default 0, SHALL, when 1, make register 0 read as zero and ignore writes to it.
REQ-005 Derived INSTR_WIDTH SHALL be 2+3*REG_ADDR_BITS+OFFSET_WIDTH+4, which is 20 at defaults.
REQ-006 clk  in  1  sole clock; all state changes on its rising edge.
REQ-007 rst  in  1  synchronous, active-low reset.
REQ-008 instr  in  INSTR_WIDTH  instruction word; MSB down: type[2], rd, rs1, rs2, offset, opcode[3:0].
REQ-009 instr_valid  in  1  instr is valid this cycle.
REQ-010 instr_ready  out  1  CU is in FETCH and can accept an instruction.
REQ-011 result2  in  DATA_WIDTH  ALU result or memory read data, used for write-back.
REQ-012 mem_ready  in  1  memory completes the current access.
REQ-013 operand1, operand2  out  DATA_WIDTH each  datapath operands.
REQ-014 offset  out  OFFSET_WIDTH  immediate offset.
REQ-015 opcode  out  4  ALU opcode.
REQ-016 sel1, sel3, w_r  out  1 each  datapath mux selects and memory write enable.
REQ-017 retired  out  16  count of completed instructions.
REQ-018 dbg_sel  in  REG_ADDR_BITS  register index for the debug read.
REQ-019 dbg_data  out  DATA_WIDTH  combinational read of regfile[dbg_sel], honouring ZERO_REG.

Function
REQ-020 The FSM SHALL have states FETCH, DECODE, EXECUTE, MEM_ACCESS and WRITE_BACK; any unreachable encoding SHALL go to FETCH on the next edge.
REQ-021 instr_ready SHALL be 1 only in FETCH.
REQ-022 In FETCH with instr_valid=1, the CU SHALL latch instr internally. Type 00 is discarded and the CU stays in FETCH; types 01, 10 and 11 move to DECODE.
REQ-023 instr SHALL be ignored outside a FETCH handshake, so later changes to it do not affect the instruction in flight.
REQ-024 On the DECODE->EXECUTE edge the CU SHALL load the outputs as follows:
- operand1 = reg[rs1] for all types.
- operand2 = reg[rs2] for type 01, reg[rd] for types 10 and 11.
- offset and opcode from the instruction fields.
- sel1/sel3 = 1/0 for type 01, 0/1 for type 10, 1/1 for type 11.
REQ-025 These outputs SHALL hold until the next DECODE->EXECUTE edge.
REQ-026 Type 01 (std_op) SHALL run DECODE -> EXECUTE -> WRITE_BACK -> FETCH.
REQ-027 Type 10 (loadR) SHALL run DECODE -> EXECUTE -> MEM_ACCESS -> WRITE_BACK -> FETCH.
REQ-028 Type 11 (storeR) SHALL run DECODE -> EXECUTE -> MEM_ACCESS -> FETCH, with no write-back.
REQ-029 MEM_ACCESS SHALL stay in place while mem_ready=0 (unbounded stall) and leave on the first edge that samples mem_ready=1.
REQ-030 For storeR, w_r SHALL go to 1 on the edge entering MEM_ACCESS and to 0 on the edge leaving it; w_r SHALL be 0 at all other times.
REQ-031 On the edge leaving WRITE_BACK, regfile[rd] SHALL be loaded with result2, except when ZERO_REG=1 and rd=0.
REQ-032 retired SHALL increment by 1 on each WRITE_BACK->FETCH edge and each storeR MEM_ACCESS->FETCH edge, and SHALL wrap from 0xFFFF to 0.
REQ-033 Latency from the accept edge to instr_ready high again SHALL be:
- std_op: 4 cycles.
- loadR: 5 cycles plus mem_ready stall cycles.
- storeR: 4 cycles plus stall cycles.
REQ-034 All outputs except dbg_data SHALL be registered.

Reset
REQ-035 rst=0 at a rising edge SHALL, from any state including mid-MEM_ACCESS stall, force:
- FSM to FETCH;
- regfile[i] = i truncated to DATA_WIDTH (reg 0 reads 0 regardless);
- operand1, operand2, offset = 0 and opcode = 4'b1111;
- sel1, sel3, w_r = 0 and retired = 0.
REQ-036 While rst=0, instr_ready SHALL be 0 and no handshake SHALL be accepted; instr_ready SHALL rise on the first edge sampling rst=1.

Verification
REQ-037 Reset: hold rst=0 for 2 cycles then release -> dbg_data for indices 0..3 reads 0, 1, 2, 3; opcode = 4'hF; instr_ready = 1 one edge after release.
REQ-038 std_op: instr=20'h76000 (rd=3, rs1=1, rs2=2) with result2=8'h03 -> operand1=1, operand2=2, sel1/sel3=1/0; reg3=8'h03 after 4 cycles; retired=1.
REQ-039 loadR: instr=20'h98050 (rd=1, rs1=2, offset=5), mem_ready low 3 cycles, then result2=8'hAA -> CU held in MEM_ACCESS for 3 cycles; operand1=2, offset=8'h05, sel1/sel3=0/1; reg1=8'hAA.
REQ-040 storeR: instr=20'hE0100 (rd=2, rs1=0, offset=8'h10), mem_ready high after 2 cycles -> w_r=1 for exactly 3 cycles; operand2=2; no regfile change; retired increments.
REQ-041 Type 00 accepted, then rst=0 during a storeR stall -> type 00 causes no state change and retired unchanged; the reset drops w_r to 0 on the same edge and returns to FETCH with reset values.
REQ-042 ZERO_REG=1 instance: std_op with rd=0 and result2=8'h55 -> dbg_data[0] stays 0, and a following instruction with rs1=0 yields operand1=0.

Source files
------------

// File: rtl/multicycle_cu.sv
// Multi-cycle control unit: fetch/decode/execute/memory/write-back sequencing,
// a small register file and registered datapath controls.
module multicycle_cu #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned REG_ADDR_BITS = 2,
    parameter int unsigned OFFSET_WIDTH  = 8,
    parameter int unsigned ZERO_REG      = 0,
    localparam int unsigned INSTR_WIDTH  = 2 + 3 * REG_ADDR_BITS + OFFSET_WIDTH + 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [INSTR_WIDTH-1:0]   instr,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic [DATA_WIDTH-1:0]    result2,
    input  logic                     mem_ready,
    output logic [DATA_WIDTH-1:0]    operand1,
    output logic [DATA_WIDTH-1:0]    operand2,
    output logic [OFFSET_WIDTH-1:0]  offset,
    output logic [3:0]               opcode,
    output logic                     sel1,
    output logic                     sel3,
    output logic                     w_r,
    output logic [15:0]              retired,
    input  logic [REG_ADDR_BITS-1:0] dbg_sel,
    output logic [DATA_WIDTH-1:0]    dbg_data
);

    localparam int unsigned NUM_REGS = 2 ** REG_ADDR_BITS;
    localparam int unsigned OFF_LSB  = 4;
    localparam int unsigned RS2_LSB  = OFF_LSB + OFFSET_WIDTH;
    localparam int unsigned RS1_LSB  = RS2_LSB + REG_ADDR_BITS;
    localparam int unsigned RD_LSB   = RS1_LSB + REG_ADDR_BITS;
    localparam int unsigned TYP_LSB  = RD_LSB + REG_ADDR_BITS;

    localparam logic [1:0] T_NOP   = 2'b00;
    localparam logic [1:0] T_STD   = 2'b01;
    localparam logic [1:0] T_LOAD  = 2'b10;
    localparam logic [1:0] T_STORE = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4
    } state_e;

    state_e                   state_q, state_d;
    logic [INSTR_WIDTH-1:0]   instr_q, instr_d;
    logic [DATA_WIDTH-1:0]    op1_q, op1_d, op2_q, op2_d;
    logic [OFFSET_WIDTH-1:0]  off_q, off_d;
    logic [3:0]               opc_q, opc_d;
    logic                     sel1_q, sel1_d, sel3_q, sel3_d, w_r_q, w_r_d;
    logic                     ready_q, ready_d;
    logic [15:0]              retired_q, retired_d;
    logic [DATA_WIDTH-1:0]    rf_q  [NUM_REGS];
    logic [DATA_WIDTH-1:0]    rf_rd [NUM_REGS];
    logic                     rf_we_c;
    logic                     accept_c;

    logic [1:0]               typ_c;
    logic [REG_ADDR_BITS-1:0] rd_c, rs1_c, rs2_c;

    assign typ_c    = instr_q[TYP_LSB +: 2];
    assign rd_c     = instr_q[RD_LSB +: REG_ADDR_BITS];
    assign rs1_c    = instr_q[RS1_LSB +: REG_ADDR_BITS];
    assign rs2_c    = instr_q[RS2_LSB +: REG_ADDR_BITS];
    assign accept_c = (state_q == S_FETCH) && ready_q && instr_valid;

    // Read view of the register file with the optional hard-wired zero register
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            rf_rd[i] = ((ZERO_REG != 0) && (i == 0)) ? '0 : rf_q[REG_ADDR_BITS'(i)];
        end
    end

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            instr_q   <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            off_q     <= '0;
            opc_q     <= 4'hF;
            sel1_q    <= 1'b0;
            sel3_q    <= 1'b0;
            w_r_q     <= 1'b0;
            ready_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            off_q     <= off_d;
            opc_q     <= opc_d;
            sel1_q    <= sel1_d;
            sel3_q    <= sel3_d;
            w_r_q     <= w_r_d;
            ready_q   <= ready_d;
            retired_q <= retired_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:   if (accept_c && (instr[TYP_LSB +: 2] != T_NOP)) state_d = S_DECODE;
            S_DECODE:  state_d = S_EXECUTE;
            S_EXECUTE: state_d = (typ_c == T_STD) ? S_WB : S_MEM;
            S_MEM:     if (mem_ready) state_d = (typ_c == T_STORE) ? S_FETCH : S_WB;
            S_WB:      state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    // Output / datapath-control next values
    always_comb begin
        instr_d   = instr_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        off_d     = off_q;
        opc_d     = opc_q;
        sel1_d    = sel1_q;
        sel3_d    = sel3_q;
        retired_d = retired_q;
        if (accept_c) instr_d = instr;
        if (state_q == S_DECODE) begin
            op1_d  = rf_rd[rs1_c];
            op2_d  = (typ_c == T_STD) ? rf_rd[rs2_c] : rf_rd[rd_c];
            off_d  = instr_q[OFF_LSB +: OFFSET_WIDTH];
            opc_d  = instr_q[3:0];
            sel1_d = (typ_c != T_LOAD);
            sel3_d = (typ_c != T_STD);
        end
        w_r_d   = (state_d == S_MEM) && (typ_c == T_STORE);
        ready_d = (state_d == S_FETCH);
        rf_we_c = (state_q == S_WB) && !((ZERO_REG != 0) && (rd_c == '0));
        if ((state_q == S_WB) || ((state_q == S_MEM) && mem_ready && (typ_c == T_STORE)))
            retired_d = retired_q + 16'd1;
    end

    // Register file: reset to index values, written on leaving WRITE_BACK
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) rf_q[REG_ADDR_BITS'(i)] <= DATA_WIDTH'(i);
        end else if (rf_we_c) begin
            rf_q[rd_c] <= result2;
        end
    end

    assign instr_ready = ready_q;
    assign operand1    = op1_q;
    assign operand2    = op2_q;
    assign offset      = off_q;
    assign opcode      = opc_q;
    assign sel1        = sel1_q;
    assign sel3        = sel3_q;
    assign w_r         = w_r_q;
    assign retired     = retired_q;
    assign dbg_data    = rf_rd[dbg_sel];

endmodule
